mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit that sits in stage E alongside the ALU.
- It owns the HI/LO registers and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- It is the responder side of the control unit's stall protocol. Control issues an operation with `start`; the unit reports occupancy on `busy`; control holds D/F and flushes E while the unit is occupied.
- The HI/LO read result is forwarded into the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (minimum 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (minimum 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is an MDU op; qualifies `op`.
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- busy  out  1  registered; high while a mult/div is in flight.
- occupied  out  1  combinational: busy OR (start AND op in 0..3). Control stalls D when the D-stage instruction is an MDU op and `occupied` is high.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- rdata  out  32  combinational: hi when op=6, lo when op=7, else 0.

Behaviour:
- Reset values: busy=0, hi=0, lo=0, internal counter=0, state=IDLE. rst wins over every other input in the same cycle and aborts any in-flight op; pending results are discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; a counter counts down; pending hi/lo are held in shadow registers, computed at accept.
- IDLE to RUN: start=1 with op 0..3 at an edge.
  - Operands are captured at that edge.
  - Counter loads MULT_CYCLES-1 or DIV_CYCLES-1.
  - busy rises the next cycle.
- RUN, counter≠0: decrement.
- RUN, counter=0: at the edge, hi/lo take the shadow values, busy falls and state returns to IDLE. New hi/lo are visible the cycle busy is low.
- Latency: with start at cycle T, busy is high for cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES. hi/lo are updated at the end of cycle T+N.
- Arithmetic:
  - MULT: signed 32x32→64; hi={upper 32}, lo={lower 32}.
  - MULTU: unsigned 32x32→64; same hi/lo split.
  - DIV: signed; quotient truncates toward zero, remainder takes the sign of the dividend. lo=quotient, hi=remainder.
  - DIVU: unsigned; lo=quotient, hi=remainder.
  - DIV with a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (b=0, DIV or DIVU): the op still occupies the full DIV_CYCLES; hi and lo are left unchanged at completion.
- MTHI/MTLO in IDLE: single cycle; hi or lo := a at the edge; busy stays 0; the other register is untouched.
- MFHI/MFLO: purely combinational read via rdata; no state change.
  - When a completion edge coincides with MFHI/MFLO start, rdata shows the pre-update value.
  - Control never issues MFHI/MFLO while occupied, so this case is unreachable in correct operation.
- start with any op while busy=1: ignored, with no state change. This is a protocol violation; an `ifdef DEBUG` assertion flags it.
- start=0: op, a and b are don't-care.
- Back-to-back: a new mult/div start is accepted in the first cycle busy=0 after completion.

Test Plan:
- Reset: rst=1 for 2 cycles after random ops -> busy=0, hi=0, lo=0, rdata=0 with op=6.
- MULT: start, op=0, a=0xFFFFFFFE (-2), b=3 -> busy=1 for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV signed: a=-7 (0xFFFFFFF9), b=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
- Divide by zero: hi=0x11, lo=0x22 preset via MTHI/MTLO, then DIVU b=0 -> 10 busy cycles, hi=0x11, lo=0x22 unchanged.
- Occupancy/ignore:
  - start op=0 -> occupied=1 that cycle, busy=1 next.
  - MTLO a=0x55 issued mid-run -> ignored; lo equals the product at completion.
  - MFLO after busy falls -> rdata equals the product's lo.
- Reset mid-operation: start DIV, assert rst at busy cycle 3 -> next cycle busy=0, hi=lo=0; no late update occurs after the original completion time.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit for the E stage.
// Owns the architectural HI/LO registers and answers the control unit's
// stall protocol through busy/occupied.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no op in flight; MTHI/MTLO write directly, mult/div can start
// RUN   | mult/div in flight; counter runs down, result waits in shadow regs
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        occupied,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   shadow_hi;
  logic [31:0]   shadow_lo;
  logic          skip_update;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   b_mag_safe;
  logic [31:0]   b_safe;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   next_hi;
  logic [31:0]   next_lo;
  logic          is_muldiv;

  assign is_muldiv = ~op[2];
  assign occupied  = busy | (start & is_muldiv);

  // HI/LO read port; shows the current registers, never the pending result
  always_comb begin
    rdata = 32'd0;
    if (op == OP_MFHI) rdata = hi;
    else if (op == OP_MFLO) rdata = lo;
  end

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes so 0x80000000 / -1 and the sign
  // rules fall out naturally; a zero divisor is replaced by 1 to keep the
  // dividers defined (the result is discarded in that case anyway).
  assign a_mag      = a[31] ? (~a + 32'd1) : a;
  assign b_mag      = b[31] ? (~b + 32'd1) : b;
  assign b_mag_safe = (b == 32'd0) ? 32'd1 : b_mag;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign q_mag      = a_mag / b_mag_safe;
  assign r_mag      = a_mag % b_mag_safe;

  // Result computed at accept time from the operands present at the start edge
  always_comb begin
    next_hi = 32'd0;
    next_lo = 32'd0;
    case (op)
      OP_MULT: begin
        next_hi = prod_s[63:32];
        next_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        next_hi = prod_u[63:32];
        next_lo = prod_u[31:0];
      end
      OP_DIV: begin
        next_lo = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
        next_hi = a[31] ? (~r_mag + 32'd1) : r_mag;
      end
      OP_DIVU: begin
        next_lo = a / b_safe;
        next_hi = a % b_safe;
      end
      default: begin
        next_hi = 32'd0;
        next_lo = 32'd0;
      end
    endcase
  end

  // Sequencer: accepts ops in IDLE, counts down in RUN, commits at count zero
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      cnt         <= '0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      shadow_hi   <= 32'd0;
      shadow_lo   <= 32'd0;
      skip_update <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state       <= RUN;
                busy        <= 1'b1;
                cnt         <= op[1] ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                shadow_hi   <= next_hi;
                shadow_lo   <= next_lo;
                skip_update <= op[1] && (b == 32'd0);
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            if (!skip_update) begin
              hi <= shadow_hi;
              lo <= shadow_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEBUG
  // Control must never issue an MDU op while a mult/div is in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(start && busy))
        else $error("mdu_ctrl: start asserted while busy");
    end
  end
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed tests for mdu_ctrl with hand-computed results.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        occupied;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int n_vec = 0;
  int n_err = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .occupied (occupied),
    .hi       (hi),
    .lo       (lo),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] x);
    start = 1'b1;
    op    = o;
    a     = x;
    tick();
    idle_inputs();
  endtask

  // Issue a mult/div and count busy cycles until it drops (bounded)
  task automatic issue_wait(input logic [2:0] o, input logic [31:0] x,
                            input logic [31:0] y, output int cycles);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    idle_inputs();
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset;
    move_to(3'd4, 32'hDEAD_BEEF);
    move_to(3'd5, 32'h1234_5678);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd7;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    op = 3'd6;
    #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++;
    if (hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_vec++;
    if (lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_vec++;
    if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    op = 3'd0;
  endtask

  task automatic test_mult;
    int cyc;
    issue_wait(3'd0, 32'hFFFF_FFFE, 32'd3, cyc);
    n_vec++;
    if (cyc !== 5) begin n_err++; $display("FAIL mult_cycles: got %0d want 5", cyc); end
    n_vec++;
    if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_vec++;
    if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    issue_wait(3'd1, 32'hFFFF_FFFE, 32'd3, cyc);
    n_vec++;
    if (cyc !== 5) begin n_err++; $display("FAIL multu_cycles: got %0d want 5", cyc); end
    n_vec++;
    if (hi !== 32'h0000_0002) begin n_err++; $display("FAIL multu_hi: got %h want 00000002", hi); end
    n_vec++;
    if (lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL multu_lo: got %h want fffffffa", lo); end
  endtask

  task automatic test_div;
    int cyc;
    issue_wait(3'd2, 32'hFFFF_FFF9, 32'd2, cyc);
    n_vec++;
    if (cyc !== 10) begin n_err++; $display("FAIL div_cycles: got %0d want 10", cyc); end
    n_vec++;
    if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_vec++;
    if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    issue_wait(3'd3, 32'd7, 32'd2, cyc);
    n_vec++;
    if (cyc !== 10) begin n_err++; $display("FAIL divu_cycles: got %0d want 10", cyc); end
    n_vec++;
    if (lo !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h want 00000003", lo); end
    n_vec++;
    if (hi !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h want 00000001", hi); end
    issue_wait(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_vec++;
    if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    n_vec++;
    if (hi !== 32'd0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
    issue_wait(3'd2, 32'd100, 32'hFFFF_FFF9, cyc);
    n_vec++;
    if (lo !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL div_negdiv_lo: got %h want fffffff2", lo); end
    n_vec++;
    if (hi !== 32'd2) begin n_err++; $display("FAIL div_negdiv_hi: got %h want 00000002", hi); end
  endtask

  task automatic test_div_zero;
    int cyc;
    move_to(3'd4, 32'h11);
    move_to(3'd5, 32'h22);
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL mt_busy: got %b want 0", busy); end
    n_vec++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      n_err++; $display("FAIL mt_preset: got hi=%h lo=%h want hi=00000011 lo=00000022", hi, lo);
    end
    issue_wait(3'd3, 32'd1234, 32'd0, cyc);
    n_vec++;
    if (cyc !== 10) begin n_err++; $display("FAIL divz_cycles: got %0d want 10", cyc); end
    n_vec++;
    if (hi !== 32'h11) begin n_err++; $display("FAIL divz_hi: got %h want 00000011", hi); end
    n_vec++;
    if (lo !== 32'h22) begin n_err++; $display("FAIL divz_lo: got %h want 00000022", lo); end
    issue_wait(3'd2, 32'hFFFF_FF00, 32'd0, cyc);
    n_vec++;
    if (cyc !== 10 || hi !== 32'h11 || lo !== 32'h22) begin
      n_err++; $display("FAIL divz_signed: got cyc=%0d hi=%h lo=%h want 10 00000011 00000022", cyc, hi, lo);
    end
  endtask

  task automatic test_occupancy;
    int cyc;
    start = 1'b1; op = 3'd0; a = 32'h1234; b = 32'h10;
    #1;
    n_vec++;
    if (occupied !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL occ_start: got occupied=%b busy=%b want 1 0", occupied, busy);
    end
    tick();
    idle_inputs();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL occ_busy_next: got %b want 1", busy); end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; op = 3'd5; a = 32'h55;
        #1;
        n_vec++;
        if (occupied !== 1'b1) begin n_err++; $display("FAIL occ_midrun: got %b want 1", occupied); end
      end
      tick();
      idle_inputs();
    end
    n_vec++;
    if (cyc !== 5) begin n_err++; $display("FAIL occ_cycles: got %0d want 5", cyc); end
    n_vec++;
    if (lo !== 32'h0001_2340 || hi !== 32'd0) begin
      n_err++; $display("FAIL occ_ignore_mtlo: got hi=%h lo=%h want 00000000 00012340", hi, lo);
    end
    n_vec++;
    if (occupied !== 1'b0) begin n_err++; $display("FAIL occ_idle: got %b want 0", occupied); end
    start = 1'b1; op = 3'd7;
    #1;
    n_vec++;
    if (rdata !== 32'h0001_2340) begin n_err++; $display("FAIL mflo_rdata: got %h want 00012340", rdata); end
    n_vec++;
    if (occupied !== 1'b0) begin n_err++; $display("FAIL mflo_occupied: got %b want 0", occupied); end
    op = 3'd6;
    #1;
    n_vec++;
    if (rdata !== 32'd0) begin n_err++; $display("FAIL mfhi_rdata: got %h want 00000000", rdata); end
    tick();
    idle_inputs();
    n_vec++;
    if (busy !== 1'b0 || lo !== 32'h0001_2340) begin
      n_err++; $display("FAIL mf_nostate: got busy=%b lo=%h want 0 00012340", busy, lo);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    issue_wait(3'd1, 32'd6, 32'd7, cyc);
    n_vec++;
    if (lo !== 32'd42 || hi !== 32'd0) begin
      n_err++; $display("FAIL b2b_first: got hi=%h lo=%h want 00000000 0000002a", hi, lo);
    end
    issue_wait(3'd3, 32'd100, 32'd7, cyc);
    n_vec++;
    if (cyc !== 10) begin n_err++; $display("FAIL b2b_cycles: got %0d want 10", cyc); end
    n_vec++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      n_err++; $display("FAIL b2b_second: got hi=%h lo=%h want 00000002 0000000e", hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd3;
    tick();
    idle_inputs();
    tick();
    tick();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy3: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL rmid_after: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
    end
    n_vec++;
    if (bad !== 0) begin n_err++; $display("FAIL rmid_late_update: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_occupancy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
